mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have ports a_req, b_req, input, 1, access request from requester A / B.
REQ-006 The block SHALL have ports a_we, b_we, input, 1, 1 = write, 0 = read.
REQ-007 The block SHALL have ports a_addr, b_addr, input, ADDR_W, access address.
REQ-008 The block SHALL have ports a_wdata, b_wdata, input, DATA_W, write data.
REQ-009 The block SHALL have ports a_gnt, b_gnt, output, 1, access accepted this cycle.
REQ-010 The block SHALL have ports a_rvalid, b_rvalid, output, 1, read data valid.
REQ-011 The block SHALL have ports a_rdata, b_rdata, output, DATA_W, read data.
REQ-012 The block SHALL have ports mem_addr (ADDR_W), mem_we (1), mem_wdata (DATA_W), all outputs, driving the single-port memory.
REQ-013 The block SHALL have port mem_rdata, input, DATA_W, combinational read data for mem_addr.
REQ-014 The block SHALL have ports a_cnt, b_cnt, output, 8, grants issued per requester.

Function
REQ-015 The block SHALL issue at most one grant per cycle; a_gnt and b_gnt are never both 1.
REQ-016 The grant SHALL be combinational from req and the priority pointer: a lone requester is granted in the same cycle.
REQ-017 The priority pointer SHALL have two states, PRI_A and PRI_B; on simultaneous requests the port named by the pointer wins.
REQ-018 After any grant to A the pointer SHALL move to PRI_B; after any grant to B it SHALL move to PRI_A; with no grant it holds.
REQ-019 The memory outputs SHALL be muxed from the granted port; mem_we = granted port's we AND grant.
REQ-020 With no grant, mem_we SHALL be 0; mem_addr and mem_wdata are don't-care.
REQ-021 A granted read SHALL capture mem_rdata into the port's rdata register at that posedge.
REQ-022 The port's rvalid SHALL be 1 for exactly the following cycle; read latency is 1 cycle from grant.
REQ-023 A granted write SHALL produce no rvalid.
REQ-024 rdata SHALL hold its last captured value until the next read grant to that port.
REQ-025 A requester SHALL hold req, we, addr and wdata stable until gnt; the block SHALL not buffer ungranted requests.
REQ-026 A requester MAY keep req high across cycles to issue back-to-back accesses; each gnt cycle is one access.
REQ-027 Under continuous requests from both ports, grants SHALL strictly alternate A, B, A, B; no port waits more than 1 cycle.
REQ-028 A read and write to the same address in consecutive cycles SHALL return the newly written value, because the memory writes at posedge.
REQ-029 a_cnt and b_cnt SHALL increment by 1 per grant and wrap 255 -> 0.

Reset
REQ-030 On rst assertion, immediately and asynchronously: pointer = PRI_A, a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0, a_cnt = b_cnt = 0.
REQ-031 During rst, a_gnt, b_gnt and mem_we SHALL be forced to 0.
REQ-032 A read granted in the cycle rst asserts SHALL produce no rvalid after reset release.
REQ-033 After rst deasserts, the first posedge SHALL behave as a normal cycle with pointer PRI_A.

Verification
REQ-034 Reset, then A writes 0x5A to 0x10 -> a_gnt=1 same cycle, mem_we=1, mem_addr=0x10, a_cnt=1.
REQ-035 A reads 0x10 after that write -> a_gnt=1, next cycle a_rvalid=1, a_rdata=0x5A, b_rvalid=0.
REQ-036 Both ports hold req=1 for 6 cycles after reset -> grant order A,B,A,B,A,B; a_cnt=b_cnt=3.
REQ-037 B writes 0x33 to 0x20, next cycle A reads 0x20 -> a_rdata=0x33 one cycle after A's grant.
REQ-038 Assert rst in a read-grant cycle to port B -> b_rvalid=0, pointer PRI_A, counters 0; a simultaneous A+B request after release grants A first.
REQ-039 Issue 256 grants to A -> a_cnt wraps to 0; throughout the run, a_gnt and b_gnt are never both 1 (assertion).

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory with combinational
// read data. Grants are combinational and round-robin via a two-state
// priority pointer. Granted reads return data one cycle later through
// per-port rdata/rvalid registers. Per-port 8-bit grant counters wrap.
//
// Handshake: a requester raises req with we/addr/wdata and holds them
// stable until it sees gnt=1 in the same cycle; that cycle is the single
// access. Keeping req high after gnt issues the next access. Ungranted
// requests are never buffered here.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_we,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        a_cnt,
    output logic [7:0]        b_cnt,
    output logic              dbg_pri_o
);

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_e;

    pri_e              pri_q, pri_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic [7:0]        a_cnt_q, a_cnt_d;
    logic [7:0]        b_cnt_q, b_cnt_d;

    // Grant decision and pointer next state: lone requester wins, a tie
    // goes to the pointer's port; nothing is granted while in reset.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        pri_d = pri_q;
        if (!rst) begin
            if (a_req && (!b_req || pri_q == PRI_A)) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
        if (a_gnt) begin
            pri_d = PRI_B;
        end else if (b_gnt) begin
            pri_d = PRI_A;
        end
    end

    // Memory port follows the granted requester; A's fields when idle.
    always_comb begin
        mem_addr  = b_gnt ? b_addr  : a_addr;
        mem_wdata = b_gnt ? b_wdata : a_wdata;
        mem_we    = (a_gnt & a_we) | (b_gnt & b_we);
    end

    // Read capture, one-cycle rvalid pulse and grant counters.
    always_comb begin
        a_rvalid_d = a_gnt & ~a_we;
        b_rvalid_d = b_gnt & ~b_we;
        a_rdata_d  = a_rvalid_d ? mem_rdata : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? mem_rdata : b_rdata_q;
        a_cnt_d    = a_cnt_q + {7'd0, a_gnt};
        b_cnt_d    = b_cnt_q + {7'd0, b_gnt};
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri_q      <= PRI_A;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_cnt_q    <= 8'd0;
            b_cnt_q    <= 8'd0;
        end else begin
            pri_q      <= pri_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
        end
    end

    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign a_cnt     = a_cnt_q;
    assign b_cnt     = b_cnt_q;
    assign dbg_pri_o = (pri_q == PRI_B);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model
// (who wins, what memory holds, what each port should see next cycle).
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       a_req, b_req, a_we, b_we;
    logic [7:0] a_addr, b_addr, a_wdata, b_wdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;
    logic [7:0] a_cnt, b_cnt;
    logic       dbg_pri;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .a_cnt(a_cnt), .b_cnt(b_cnt), .dbg_pri_o(dbg_pri)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment memory ----------------
    logic [7:0] env_mem [256];
    assign mem_rdata = env_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr] <= mem_wdata;
    end

    // ---------------- counters / check helper ----------------
    int n_checks;
    int n_pass;
    bit chk_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_mem [256];
    bit         m_last_a;   // 1: A won the most recent grant, so B is preferred
    int         m_a_cnt, m_b_cnt;
    bit         m_a_rv, m_b_rv;
    logic [7:0] m_a_rd, m_b_rd;

    task automatic m_reset();
        m_last_a = 1'b0;
        m_a_cnt  = 0;
        m_b_cnt  = 0;
        m_a_rv   = 1'b0;
        m_b_rv   = 1'b0;
        m_a_rd   = 8'h00;
        m_b_rd   = 8'h00;
    endtask

    // Compare process: outputs at the falling edge, then advance the model.
    always @(negedge clk) begin
        bit eg_a, eg_b;
        if (chk_en) begin
            if (rst) begin
                m_reset();
                chk("rst_a_gnt", a_gnt, 0);
                chk("rst_b_gnt", b_gnt, 0);
                chk("rst_mem_we", mem_we, 0);
            end
            eg_a = !rst && a_req && (!b_req || !m_last_a);
            eg_b = !rst && b_req && !eg_a;
            if (!rst) begin
                chk("a_gnt", a_gnt, eg_a);
                chk("b_gnt", b_gnt, eg_b);
                chk("mem_we", mem_we, (eg_a && a_we) || (eg_b && b_we));
                if (eg_a) chk("mem_addr_a", mem_addr, a_addr);
                if (eg_b) chk("mem_addr_b", mem_addr, b_addr);
                if (eg_a && a_we) chk("mem_wdata_a", mem_wdata, a_wdata);
                if (eg_b && b_we) chk("mem_wdata_b", mem_wdata, b_wdata);
            end
            chk("a_rvalid", a_rvalid, m_a_rv);
            chk("b_rvalid", b_rvalid, m_b_rv);
            chk("a_rdata", a_rdata, m_a_rd);
            chk("b_rdata", b_rdata, m_b_rd);
            chk("a_cnt", a_cnt, m_a_cnt);
            chk("b_cnt", b_cnt, m_b_cnt);
            chk("pointer", dbg_pri, m_last_a);
            if (!rst) begin
                m_a_rv = eg_a && !a_we;
                m_b_rv = eg_b && !b_we;
                if (eg_a) begin
                    m_a_cnt  = (m_a_cnt + 1) % 256;
                    m_last_a = 1'b1;
                    if (a_we) m_mem[a_addr] = a_wdata;
                    else      m_a_rd = m_mem[a_addr];
                end
                if (eg_b) begin
                    m_b_cnt  = (m_b_cnt + 1) % 256;
                    m_last_a = 1'b0;
                    if (b_we) m_mem[b_addr] = b_wdata;
                    else      m_b_rd = m_mem[b_addr];
                end
            end
        end
    end

    always @(negedge clk) begin
        assert (!(a_gnt && b_gnt)) else $error("FAIL onehot: a_gnt and b_gnt both 1 at %0t", $time);
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
    endtask

    task automatic drive_a(input bit req, input bit we, input logic [7:0] addr, input logic [7:0] wd);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic drive_b(input bit req, input bit we, input logic [7:0] addr, input logic [7:0] wd);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    // Leaves rst released at posedge+1 so the caller can drive the first cycle.
    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ga, gb;
        n_checks = 0;
        n_pass   = 0;
        chk_en   = 0;
        rst      = 0;
        set_idle();
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'h00;
            m_mem[i]   = 8'h00;
        end
        m_reset();
        #1;
        rst    = 1;
        chk_en = 1;

        // A writes 0x5A to 0x10, then reads it back.
        apply_reset();
        drive_a(1, 1, 8'h10, 8'h5A);
        mid();
        chk("t1_a_gnt", a_gnt, 1);
        chk("t1_mem_we", mem_we, 1);
        chk("t1_mem_addr", mem_addr, 8'h10);
        cyc();
        drive_a(1, 0, 8'h10, 8'h00);
        mid();
        chk("t1_a_cnt", a_cnt, 1);
        chk("t1_rd_gnt", a_gnt, 1);
        cyc();
        drive_a(0, 0, 8'h00, 8'h00);
        mid();
        chk("t1_a_rvalid", a_rvalid, 1);
        chk("t1_a_rdata", a_rdata, 8'h5A);
        chk("t1_b_rvalid", b_rvalid, 0);

        // Both request continuously for six cycles: strict alternation.
        apply_reset();
        drive_a(1, 0, 8'h01, 8'h00);
        drive_b(1, 0, 8'h02, 8'h00);
        for (int i = 0; i < 6; i++) begin
            mid();
            chk("t2_a_gnt", a_gnt, (i % 2) == 0);
            chk("t2_b_gnt", b_gnt, (i % 2) == 1);
            cyc();
        end
        set_idle();
        mid();
        chk("t2_a_cnt", a_cnt, 3);
        chk("t2_b_cnt", b_cnt, 3);

        // B writes 0x33 to 0x20, A reads it in the next cycle.
        apply_reset();
        drive_b(1, 1, 8'h20, 8'h33);
        mid();
        chk("t3_b_gnt", b_gnt, 1);
        cyc();
        drive_b(0, 0, 8'h00, 8'h00);
        drive_a(1, 0, 8'h20, 8'h00);
        mid();
        chk("t3_a_gnt", a_gnt, 1);
        cyc();
        drive_a(0, 0, 8'h00, 8'h00);
        mid();
        chk("t3_a_rvalid", a_rvalid, 1);
        chk("t3_a_rdata", a_rdata, 8'h33);

        // Reset lands in a B read-grant cycle after an A write.
        apply_reset();
        drive_a(1, 1, 8'h30, 8'h77);
        cyc();
        drive_a(0, 0, 8'h00, 8'h00);
        drive_b(1, 0, 8'h30, 8'h00);
        mid();
        chk("t4_b_gnt", b_gnt, 1);
        chk("t4_a_cnt_pre", a_cnt, 1);
        chk("t4_ptr_pre", dbg_pri, 1);
        #1;
        rst = 1;
        #1;
        chk("t4_async_a_cnt", a_cnt, 0);
        chk("t4_async_ptr", dbg_pri, 0);
        chk("t4_async_b_gnt", b_gnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        drive_a(1, 0, 8'h30, 8'h00);
        drive_b(1, 0, 8'h31, 8'h00);
        mid();
        chk("t4_b_rvalid", b_rvalid, 0);
        chk("t4_first_a", a_gnt, 1);
        chk("t4_first_b", b_gnt, 0);
        cyc();
        set_idle();
        mid();
        chk("t4_a_rvalid", a_rvalid, 1);
        chk("t4_a_rdata", a_rdata, 8'h77);

        // 256 back-to-back writes from A wrap its counter.
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            drive_a(1, 1, 8'($urandom_range(0, 15)), 8'($urandom));
            if (i == 255) begin
                mid();
                chk("t5_a_cnt_255", a_cnt, 255);
            end
            cyc();
        end
        set_idle();
        mid();
        chk("t5_a_cnt_wrap", a_cnt, 0);

        // Random traffic honouring hold-until-grant.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            ga = a_gnt;
            gb = b_gnt;
            @(posedge clk); #1;
            if (!a_req || ga)
                drive_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 15)), 8'($urandom));
            if (!b_req || gb)
                drive_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 15)), 8'($urandom));
        end
        set_idle();
        mid();
        mid();
        chk_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
